onehot_pulse_decoder: RTL and testbench

- Sequential counterpart to the team's combinational 4-to-2 one-hot encoder.
- Accepts binary codes over a valid/ready handshake. Each code drives the matching one-hot output line for a programmable number of cycles, followed by an optional idle gap.
- Used to turn compact select codes from a controller into timed one-hot strobes (enables, chip selects) for downstream logic.

---
 rtl/onehot_pkg.sv | 17 +
 rtl/onehot_encode.sv | 26 ++
 rtl/onehot_pulse_decoder.sv | 151 +++++++++++++++
 tb/tb_onehot_pulse_decoder.sv | 268 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/onehot_pkg.sv
// Shared types and helpers for the one-hot pulse decoder.
// The echo self-check in the top is enabled by ONEHOT_ECHO_CHECK_EN.
package onehot_pkg;

    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StDrive = 2'd1,
        StGap   = 2'd2
    } state_e;

    localparam int unsigned CNT_W = 8;

    function automatic logic code_in_range(input int unsigned code, input int unsigned n);
        return code < n;
    endfunction

endpackage

// File: rtl/onehot_encode.sv
// One-hot to binary encoder; valid is low for an all-zero or multi-hot input.
// Only instantiated when ONEHOT_ECHO_CHECK_EN is defined.
module onehot_encode #(
    parameter int unsigned N     = 4,
    parameter int unsigned IDX_W = 2
) (
    input  logic [N-1:0]     onehot,
    output logic [IDX_W-1:0] idx,
    output logic             valid
);

    localparam logic [N-1:0] One = N'(1);

    always_comb begin
        idx = '0;
        for (int i = 0; i < int'(N); i++) begin
            if (onehot[i]) begin
                idx = idx | IDX_W'(i);
            end
        end
    end

    // x & (x-1) clears the lowest set bit; zero result means at most one bit was set.
    assign valid = (onehot != '0) && ((onehot & (onehot - One)) == '0);

endmodule

// File: rtl/onehot_pulse_decoder.sv
// Turns handshaked binary codes into timed one-hot strobes with an idle gap.
// Define ONEHOT_ECHO_CHECK_EN to add the sticky echo_err self-check output.
module onehot_pulse_decoder #(
    parameter int unsigned N     = 4,
    parameter int unsigned IDX_W = 2,
    parameter int unsigned HOLD  = 3,
    parameter int unsigned GAP   = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [IDX_W-1:0] in_code,
    output logic [N-1:0]     out_onehot,
    output logic             out_active,
    output logic             done,
    output logic             err_range
`ifdef ONEHOT_ECHO_CHECK_EN
   ,output logic             echo_err
`endif
);

    import onehot_pkg::*;

    localparam bit               RangeCheck = (N < (1 << IDX_W));
    localparam logic [N-1:0]     OneHotBase = N'(1);
    localparam logic [CNT_W-1:0] HoldLoad   = CNT_W'(HOLD - 1);
    localparam logic [CNT_W-1:0] GapLoad    = (GAP > 0) ? CNT_W'(GAP - 1) : '0;

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [N-1:0]     onehot_q, onehot_d;
    logic             active_q, active_d;
    logic             done_q, done_d;
    logic             err_q, err_d;
    logic             handshake;
    logic             in_range;

    assign in_ready  = (state_q == StIdle);
    assign handshake = in_valid && in_ready;
    // With N == 2**IDX_W every code is legal and err_range folds to constant zero.
    assign in_range  = !RangeCheck || code_in_range(32'(in_code), N);

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        onehot_d = onehot_q;
        done_d   = 1'b0;
        err_d    = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (handshake) begin
                    if (in_range) begin
                        state_d  = StDrive;
                        cnt_d    = HoldLoad;
                        onehot_d = OneHotBase << in_code;
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
            StDrive: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - 1'b1;
                end else begin
                    onehot_d = '0;
                    done_d   = 1'b1;
                    if (GAP > 0) begin
                        state_d = StGap;
                        cnt_d   = GapLoad;
                    end else begin
                        state_d = StIdle;
                        cnt_d   = '0;
                    end
                end
            end
            StGap: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - 1'b1;
                end else begin
                    state_d = StIdle;
                end
            end
            default: begin
                state_d  = StIdle;
                cnt_d    = '0;
                onehot_d = '0;
            end
        endcase
        active_d = |onehot_d;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= StIdle;
            cnt_q    <= '0;
            onehot_q <= '0;
            active_q <= 1'b0;
            done_q   <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            onehot_q <= onehot_d;
            active_q <= active_d;
            done_q   <= done_d;
            err_q    <= err_d;
        end
    end

    assign out_onehot = onehot_q;
    assign out_active = active_q;
    assign done       = done_q;
    assign err_range  = err_q;

`ifdef ONEHOT_ECHO_CHECK_EN
    logic [IDX_W-1:0] code_q;
    logic [IDX_W-1:0] enc_idx;
    logic             enc_valid;
    logic             echo_q;
    logic             echo_bad;

    onehot_encode #(
        .N     (N),
        .IDX_W (IDX_W)
    ) u_encode (
        .onehot (onehot_q),
        .idx    (enc_idx),
        .valid  (enc_valid)
    );

    // Multi-hot is illegal in any state; zero or a wrong index only while driving.
    assign echo_bad = ((onehot_q != '0) && !enc_valid) ||
                      ((state_q == StDrive) && (!enc_valid || (enc_idx != code_q)));

    always_ff @(posedge clk) begin
        if (rst) begin
            code_q <= '0;
            echo_q <= 1'b0;
        end else begin
            if (handshake && in_range) begin
                code_q <= in_code;
            end
            echo_q <= echo_q | echo_bad;
        end
    end

    assign echo_err = echo_q;
`endif

endmodule

// File: tb/tb_onehot_pulse_decoder.sv
// Scoreboard bench: three decoder instances cover the default, N=3 and HOLD=1/GAP=0 builds.
// With ONEHOT_ECHO_CHECK_EN defined, echo_err is also checked to stay low.
module tb_onehot_pulse_decoder;

    typedef struct packed {
        logic [3:0] oh;
        logic       act;
        logic       done;
        logic       rdy;
        logic       err;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;

    logic       a_valid = 1'b0, a_ready, a_active, a_done, a_err;
    logic [1:0] a_code  = '0;
    logic [3:0] a_onehot;
    logic       b_valid = 1'b0, b_ready, b_active, b_done, b_err;
    logic [1:0] b_code  = '0;
    logic [2:0] b_onehot;
    logic       c_valid = 1'b0, c_ready, c_active, c_done, c_err;
    logic [1:0] c_code  = '0;
    logic [3:0] c_onehot;
`ifdef ONEHOT_ECHO_CHECK_EN
    logic a_echo, b_echo, c_echo;
`endif

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_pass   = 0;

    always #5 clk = ~clk;

    onehot_pulse_decoder #(.N(4), .IDX_W(2), .HOLD(3), .GAP(1)) dut_a (
        .clk (clk), .rst (rst), .in_valid (a_valid), .in_ready (a_ready), .in_code (a_code),
        .out_onehot (a_onehot), .out_active (a_active), .done (a_done), .err_range (a_err)
`ifdef ONEHOT_ECHO_CHECK_EN
       ,.echo_err (a_echo)
`endif
    );

    onehot_pulse_decoder #(.N(3), .IDX_W(2), .HOLD(3), .GAP(1)) dut_b (
        .clk (clk), .rst (rst), .in_valid (b_valid), .in_ready (b_ready), .in_code (b_code),
        .out_onehot (b_onehot), .out_active (b_active), .done (b_done), .err_range (b_err)
`ifdef ONEHOT_ECHO_CHECK_EN
       ,.echo_err (b_echo)
`endif
    );

    onehot_pulse_decoder #(.N(4), .IDX_W(2), .HOLD(1), .GAP(0)) dut_c (
        .clk (clk), .rst (rst), .in_valid (c_valid), .in_ready (c_ready), .in_code (c_code),
        .out_onehot (c_onehot), .out_active (c_active), .done (c_done), .err_range (c_err)
`ifdef ONEHOT_ECHO_CHECK_EN
       ,.echo_err (c_echo)
`endif
    );

    // Expected outputs for the 1+HOLD+GAP cycles after a handshake; the last one is ready.
    function automatic void push_pulse(input int code, input int hold, input int gap);
        exp_t e;
        for (int i = 0; i < hold; i++) begin
            e      = '0;
            e.oh   = 4'b0001 << code;
            e.act  = 1'b1;
            exp_q.push_back(e);
        end
        e      = '0;
        e.done = 1'b1;
        e.rdy  = (gap == 0);
        exp_q.push_back(e);
        for (int i = 1; i < gap; i++) begin
            e = '0;
            exp_q.push_back(e);
        end
        if (gap > 0) begin
            e     = '0;
            e.rdy = 1'b1;
            exp_q.push_back(e);
        end
    endfunction

    function automatic void push_idle(input int n);
        exp_t e;
        for (int i = 0; i < n; i++) begin
            e     = '0;
            e.rdy = 1'b1;
            exp_q.push_back(e);
        end
    endfunction

    task automatic test_reset();
        exp_t got, exp;
        rst = 1'b1;
        @(posedge clk); #1;
        got = {a_onehot, a_active, a_done, a_ready, a_err};
        exp = '{oh: 4'b0000, act: 1'b0, done: 1'b0, rdy: 1'b1, err: 1'b0};
        n_checks++;
        if (got !== exp) $display("FAIL reset_hold_a: got %b required %b", got, exp);
        else n_pass++;
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;
        got = {a_onehot, a_active, a_done, a_ready, a_err};
        n_checks++;
        if (got !== exp) $display("FAIL reset_release_a: got %b required %b", got, exp);
        else n_pass++;
        got = {1'b0, b_onehot, b_active, b_done, b_ready, b_err};
        n_checks++;
        if (got !== exp) $display("FAIL reset_release_b: got %b required %b", got, exp);
        else n_pass++;
        got = {c_onehot, c_active, c_done, c_ready, c_err};
        n_checks++;
        if (got !== exp) $display("FAIL reset_release_c: got %b required %b", got, exp);
        else n_pass++;
    endtask

    task automatic test_single();
        exp_t got, exp;
        int   k = 0;
        exp_q.delete();
        a_valid = 1'b1;
        a_code  = 2'd2;
        push_pulse(2, 3, 1);
        push_idle(1);
        while (exp_q.size() > 0) begin
            @(posedge clk); #1;
            if (k == 0) a_valid = 1'b0;
            got = {a_onehot, a_active, a_done, a_ready, a_err};
            exp = exp_q.pop_front();
            n_checks++;
            if (got !== exp) $display("FAIL single k=%0d: got %b required %b", k, got, exp);
            else n_pass++;
            k++;
        end
    endtask

    task automatic test_back_to_back();
        exp_t got, exp;
        int   codes[3] = '{0, 3, 1};
        int   k = 0;
        exp_q.delete();
        @(posedge clk); #1;
        a_valid = 1'b1;
        a_code  = 2'(codes[0]);
        for (int i = 0; i < 3; i++) push_pulse(codes[i], 3, 1);
        while (exp_q.size() > 0) begin
            @(posedge clk); #1;
            if (k % 5 == 0) begin
                if (k / 5 + 1 < 3) a_code = 2'(codes[k / 5 + 1]);
                else a_valid = 1'b0;
            end
            got = {a_onehot, a_active, a_done, a_ready, a_err};
            exp = exp_q.pop_front();
            n_checks++;
            if (got !== exp) $display("FAIL back_to_back k=%0d: got %b required %b", k, got, exp);
            else n_pass++;
            k++;
        end
    endtask

    task automatic test_out_of_range();
        exp_t got, exp;
        int   k = 0;
        exp_q.delete();
        @(posedge clk); #1;
        b_valid = 1'b1;
        b_code  = 2'd3;
        exp     = '{oh: 4'b0000, act: 1'b0, done: 1'b0, rdy: 1'b1, err: 1'b1};
        exp_q.push_back(exp);
        push_pulse(1, 3, 1);
        while (exp_q.size() > 0) begin
            @(posedge clk); #1;
            if (k == 0) b_code = 2'd1;
            if (k == 1) b_valid = 1'b0;
            got = {1'b0, b_onehot, b_active, b_done, b_ready, b_err};
            exp = exp_q.pop_front();
            n_checks++;
            if (got !== exp) $display("FAIL out_of_range k=%0d: got %b required %b", k, got, exp);
            else n_pass++;
            k++;
        end
    endtask

    task automatic test_reset_mid_pulse();
        exp_t got, exp;
        int   k = 0;
        exp_q.delete();
        @(posedge clk); #1;
        a_valid = 1'b1;
        a_code  = 2'd1;
        exp     = '{oh: 4'b0010, act: 1'b1, done: 1'b0, rdy: 1'b0, err: 1'b0};
        exp_q.push_back(exp);
        exp_q.push_back(exp);
        push_idle(2);
        while (exp_q.size() > 0) begin
            @(posedge clk); #1;
            if (k == 0) a_valid = 1'b0;
            if (k == 1) rst = 1'b1;
            if (k == 2) rst = 1'b0;
            got = {a_onehot, a_active, a_done, a_ready, a_err};
            exp = exp_q.pop_front();
            n_checks++;
            if (got !== exp) $display("FAIL reset_mid k=%0d: got %b required %b", k, got, exp);
            else n_pass++;
            k++;
        end
        k = 0;
        a_valid = 1'b1;
        a_code  = 2'd3;
        push_pulse(3, 3, 1);
        while (exp_q.size() > 0) begin
            @(posedge clk); #1;
            if (k == 0) a_valid = 1'b0;
            got = {a_onehot, a_active, a_done, a_ready, a_err};
            exp = exp_q.pop_front();
            n_checks++;
            if (got !== exp) $display("FAIL after_reset k=%0d: got %b required %b", k, got, exp);
            else n_pass++;
            k++;
        end
    endtask

    task automatic test_hold_one();
        exp_t got, exp;
        int   k = 0;
        exp_q.delete();
        @(posedge clk); #1;
        c_valid = 1'b1;
        c_code  = 2'd0;
        push_pulse(0, 1, 0);
        push_pulse(1, 1, 0);
        push_idle(1);
        while (exp_q.size() > 0) begin
            @(posedge clk); #1;
            if (k == 0) c_code = 2'd1;
            if (k == 2) c_valid = 1'b0;
            got = {c_onehot, c_active, c_done, c_ready, c_err};
            exp = exp_q.pop_front();
            n_checks++;
            if (got !== exp) $display("FAIL hold_one k=%0d: got %b required %b", k, got, exp);
            else n_pass++;
`ifdef ONEHOT_ECHO_CHECK_EN
            n_checks++;
            if (c_echo !== 1'b0) $display("FAIL echo_c k=%0d: got %b required 0", k, c_echo);
            else n_pass++;
`endif
            k++;
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_back_to_back();
        test_out_of_range();
        test_reset_mid_pulse();
        test_hold_one();
`ifdef ONEHOT_ECHO_CHECK_EN
        n_checks++;
        if ({a_echo, b_echo} !== 2'b00) $display("FAIL echo_ab: got %b required 00", {a_echo, b_echo});
        else n_pass++;
`endif
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
